alu_share_arbiter: RTL

Sequential arbiter that shares the single 64-bit execute ALU between two requesters, for example the execute stage and the address/stack-pointer path. It grants one request at a time, registers the operands, drives the ALU for one cycle, captures the result with Y86 condition codes (ZF, SF, OF), and holds a response until the owning requester accepts it. It sits between the requesters and the ALU's combinational `control`/`a`/`b`/`ans`/`overflow` pins.

---
 rtl/alu_share_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Shares the single 64-bit execute ALU between two requesters; one operation in flight at a time.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration (default: fixed priority, requester 0 wins).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate, accept one request, latch operands and owner
// EXEC  | operand registers drive the ALU; capture result and {ZF,SF,OF}
// RESP  | hold response for the owner until it asserts rsp_ready
module alu_share_arbiter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req_valid_0,
    output logic         req_ready_0,
    input  logic [1:0]   req_fn_0,
    input  logic [W-1:0] req_a_0,
    input  logic [W-1:0] req_b_0,

    input  logic         req_valid_1,
    output logic         req_ready_1,
    input  logic [1:0]   req_fn_1,
    input  logic [W-1:0] req_a_1,
    input  logic [W-1:0] req_b_1,

    output logic         rsp_valid_0,
    input  logic         rsp_ready_0,
    output logic         rsp_valid_1,
    input  logic         rsp_ready_1,
    output logic [W-1:0] rsp_data,
    output logic [2:0]   rsp_cc,

    output logic [1:0]   alu_ctrl,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_ans,
    input  logic         alu_ovf,

    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         owner_q, owner_d;
    logic [1:0]   fn_q, fn_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] data_q, data_d;
    logic [2:0]   cc_q, cc_d;

    logic         win_1;
    logic         accept;
    logic         rsp_done;

`ifdef ALU_ARB_RR_EN
    // prio_q = 1 means requester 1 wins the next contention
    logic         prio_q, prio_d;

    always_comb begin
        if (req_valid_0 && req_valid_1) begin
            win_1 = prio_q;
        end else begin
            win_1 = req_valid_1;
        end
    end
`else
    always_comb begin
        win_1 = req_valid_1 && !req_valid_0;
    end
`endif

    assign req_ready_0 = (state_q == IDLE) && req_valid_0 && !win_1;
    assign req_ready_1 = (state_q == IDLE) && win_1;
    assign accept      = req_ready_0 || req_ready_1;
    assign rsp_done    = (state_q == RESP) && (owner_q ? rsp_ready_1 : rsp_ready_0);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        fn_d    = fn_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        cc_d    = cc_q;
`ifdef ALU_ARB_RR_EN
        prio_d  = prio_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = win_1;
                    fn_d    = win_1 ? req_fn_1 : req_fn_0;
                    a_d     = win_1 ? req_a_1  : req_a_0;
                    b_d     = win_1 ? req_b_1  : req_b_0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                data_d  = alu_ans;
                cc_d    = {(alu_ans == '0), alu_ans[W-1], alu_ovf};
                state_d = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
`ifdef ALU_ARB_RR_EN
                    prio_d  = !owner_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            fn_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            cc_q    <= '0;
`ifdef ALU_ARB_RR_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            fn_q    <= fn_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            cc_q    <= cc_d;
`ifdef ALU_ARB_RR_EN
            prio_q  <= prio_d;
`endif
        end
    end

    // The ALU is driven from the operand registers at all times, not just in EXEC
    assign alu_ctrl    = fn_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;

    assign rsp_valid_0 = (state_q == RESP) && !owner_q;
    assign rsp_valid_1 = (state_q == RESP) && owner_q;
    assign rsp_data    = data_q;
    assign rsp_cc      = cc_q;
    assign busy        = (state_q != IDLE);

endmodule
